// File: rtl/td4_cpu.sv
// TD4-style 4-bit single-cycle accumulator CPU: registers A/B, output port, PC and carry.
// Each clock executes one instruction fetched combinationally from an external ROM.
module td4_cpu (
  input  logic       clk,
  input  logic       n_rst,
  output logic [3:0] addr,
  input  logic [3:0] opecode,
  input  logic [3:0] imm,
  input  logic [3:0] switch,
  output logic [3:0] led
);

  localparam int unsigned W = 4;

  typedef enum logic [3:0] {
    OP_ADD_A_IM = 4'b0000,
    OP_MOV_A_B  = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_B_A  = 4'b0100,
    OP_ADD_B_IM = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_OUT_B    = 4'b1001,
    OP_OUT_IM   = 4'b1011,
    OP_JNC_IM   = 4'b1110,
    OP_JMP_IM   = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_SW   = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [W-1:0] reg_out;
  logic [W-1:0] pc;
  logic         carry;

  src_e         src_sel;
  logic         ld_a;
  logic         ld_b;
  logic         ld_out;
  logic         ld_pc;
  logic [W-1:0] src_val;
  logic [W:0]   sum_ext;

  // Instruction decode: pick the adder source and the destination register.
  always_comb begin
    src_sel = SRC_ZERO;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_out  = 1'b0;
    ld_pc   = 1'b0;
    case (opecode)
      OP_ADD_A_IM: begin src_sel = SRC_A;    ld_a   = 1'b1; end
      OP_MOV_A_B:  begin src_sel = SRC_B;    ld_a   = 1'b1; end
      OP_IN_A:     begin src_sel = SRC_SW;   ld_a   = 1'b1; end
      OP_MOV_A_IM: begin src_sel = SRC_ZERO; ld_a   = 1'b1; end
      OP_MOV_B_A:  begin src_sel = SRC_A;    ld_b   = 1'b1; end
      OP_ADD_B_IM: begin src_sel = SRC_B;    ld_b   = 1'b1; end
      OP_IN_B:     begin src_sel = SRC_SW;   ld_b   = 1'b1; end
      OP_MOV_B_IM: begin src_sel = SRC_ZERO; ld_b   = 1'b1; end
      OP_OUT_B:    begin src_sel = SRC_B;    ld_out = 1'b1; end
      OP_OUT_IM:   begin src_sel = SRC_ZERO; ld_out = 1'b1; end
      OP_JNC_IM:   begin src_sel = SRC_ZERO; ld_pc  = ~carry; end
      OP_JMP_IM:   begin src_sel = SRC_ZERO; ld_pc  = 1'b1; end
      default:     begin src_sel = SRC_ZERO; end
    endcase
  end

  // Source mux feeding the single adder; zero source guarantees a cleared carry.
  always_comb begin
    src_val = '0;
    case (src_sel)
      SRC_A:   src_val = reg_a;
      SRC_B:   src_val = reg_b;
      SRC_SW:  src_val = switch;
      default: src_val = '0;
    endcase
  end

  assign sum_ext = (W+1)'({1'b0, src_val}) + (W+1)'({1'b0, imm});

  // Architectural state commit; carry is rewritten by every instruction.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reg_a   <= '0;
      reg_b   <= '0;
      reg_out <= '0;
      pc      <= '0;
      carry   <= 1'b0;
    end else begin
      carry <= sum_ext[W];
      if (ld_a)   reg_a   <= sum_ext[W-1:0];
      if (ld_b)   reg_b   <= sum_ext[W-1:0];
      if (ld_out) reg_out <= sum_ext[W-1:0];
      pc <= ld_pc ? imm : pc + W'(1);
    end
  end

  assign addr = pc;
  assign led  = reg_out;

endmodule

// File: tb/tb_td4_cpu.sv
// Directed bench for td4_cpu: drives one instruction per clock and checks addr/led
// against hand-computed values; register and carry contents are observed through OUT/JNC.
module tb_td4_cpu;

  logic       clk;
  logic       n_rst;
  logic [3:0] addr;
  logic [3:0] opecode;
  logic [3:0] imm;
  logic [3:0] switch;
  logic [3:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  td4_cpu dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .addr    (addr),
    .opecode (opecode),
    .imm     (imm),
    .switch  (switch),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one instruction, let it execute on the next rising edge, sample 1 time unit later.
  task automatic step(input logic [3:0] op, input logic [3:0] im, input logic [3:0] sw);
    opecode = op;
    imm     = im;
    switch  = sw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst   = 1'b0;
    opecode = 4'b0000;
    imm     = 4'd0;
    switch  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", addr, 4'd0);
    check("reset_led", led, 4'd0);

    // PC walks 1..15 then wraps to 0 with ADD A,0.
    n_rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(4'b0000, 4'd0, 4'd0);
      check($sformatf("pc_walk_%0d", i), addr, 4'(i % 16));
    end
    step(4'b1011, 4'd5, 4'd0);
    check("out_im_5", led, 4'd5);
    step(4'b0100, 4'd0, 4'd0);
    step(4'b1001, 4'd0, 4'd0);
    check("a_stays_0", led, 4'd0);

    // IN / MOV / OUT path.
    step(4'b0010, 4'd0, 4'd3);   // IN A, sw=3 -> A=3
    step(4'b0100, 4'd0, 4'd0);   // MOV B,A   -> B=3
    step(4'b0010, 4'd0, 4'd6);   // IN A, sw=6 -> A=6
    step(4'b1001, 4'd0, 4'd9);   // OUT B     -> led=3
    check("out_b_3", led, 4'd3);
    step(4'b0100, 4'd0, 4'd0);   // B=A=6
    step(4'b1001, 4'd0, 4'd0);
    check("in_a_6", led, 4'd6);
    step(4'b1011, 4'd9, 4'd0);
    check("out_im_9", led, 4'd9);
    step(4'b0110, 4'd2, 4'd5);   // IN B with imm: 5+2 -> B=7
    step(4'b1001, 4'd0, 4'd0);
    check("in_b_imm", led, 4'd7);
    step(4'b0001, 4'd1, 4'd0);   // MOV A,B +1 -> A=8
    step(4'b0100, 4'd0, 4'd0);   // B=8
    step(4'b1001, 4'd3, 4'd0);   // OUT B +3 -> led=11
    check("mov_a_b_out_imm", led, 4'd11);

    // Immediate / add / carry with JNC not taken.
    step(4'b1111, 4'd2, 4'd0);
    check("jmp_2", addr, 4'd2);
    step(4'b0011, 4'd10, 4'd0);  // A=10, C=0 (addr 3)
    step(4'b0000, 4'd10, 4'd0);  // A=4, C=1  (addr 4)
    step(4'b1110, 4'd7, 4'd0);   // not taken -> addr 5, C=0
    check("jnc_not_taken", addr, 4'd5);
    step(4'b1110, 4'd12, 4'd0);  // C cleared by JNC -> taken
    check("jnc_clears_c", addr, 4'd12);
    step(4'b0100, 4'd0, 4'd0);
    step(4'b1001, 4'd0, 4'd0);
    check("add_a_wrap_4", led, 4'd4);

    // JNC taken after a carry-free MOV A,Im.
    step(4'b0011, 4'd1, 4'd0);
    step(4'b1110, 4'd7, 4'd0);
    check("jnc_taken", addr, 4'd7);

    // JMP and ADD B overflow.
    step(4'b1111, 4'd3, 4'd0);
    check("jmp_3", addr, 4'd3);
    step(4'b0111, 4'd1, 4'd0);   // B=1        (addr 4)
    step(4'b0101, 4'd15, 4'd0);  // B=0, C=1   (addr 5)
    step(4'b1110, 4'd9, 4'd0);   // not taken  (addr 6)
    check("add_b_carry", addr, 4'd6);
    step(4'b1001, 4'd0, 4'd0);
    check("add_b_wrap_0", led, 4'd0);
    step(4'b0101, 4'd15, 4'd0);  // B=15, C=0
    step(4'b1110, 4'd10, 4'd0);
    check("add_b_no_carry", addr, 4'd10);
    step(4'b0000, 4'd0, 4'd0);   // A unchanged via ADD 0; C=0 (addr 11)
    step(4'b0101, 4'd1, 4'd0);   // B=0, C=1 (addr 12)
    step(4'b0011, 4'd0, 4'd0);   // MOV A,Im clears C (addr 13)
    step(4'b1110, 4'd2, 4'd0);
    check("mov_im_clears_c", addr, 4'd2);

    // NOPs write nothing and clear carry.
    begin
      logic [3:0] nops [4];
      nops[0] = 4'b1000; nops[1] = 4'b1010; nops[2] = 4'b1100; nops[3] = 4'b1101;
      for (int k = 0; k < 4; k++) begin
        step(4'b1011, 4'd6, 4'd0);   // led=6
        step(4'b0011, 4'd15, 4'd0);  // A=15
        step(4'b0000, 4'd1, 4'd0);   // A=0, C=1
        step(nops[k], 4'd9, 4'd9);
        check($sformatf("nop_%0d_led", k), led, 4'd6);
        step(4'b1110, 4'd12, 4'd0);
        check($sformatf("nop_%0d_clears_c", k), addr, 4'd12);
      end
    end

    // PC wrap via JMP 15 then NOP.
    step(4'b1111, 4'd15, 4'd0);
    step(4'b1000, 4'd0, 4'd0);
    check("pc_wrap", addr, 4'd0);

    // Asynchronous reset between edges with nonzero state.
    step(4'b0011, 4'd5, 4'd0);
    step(4'b0100, 4'd0, 4'd0);
    step(4'b1001, 4'd0, 4'd0);
    check("pre_reset_led", led, 4'd5);
    check("pre_reset_addr", addr, 4'd3);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_addr", addr, 4'd0);
    check("async_rst_led", led, 4'd0);
    #2;
    n_rst = 1'b1;
    step(4'b0100, 4'd0, 4'd0);   // executes addr 0: B=A=0
    check("post_rst_addr", addr, 4'd1);
    step(4'b0001, 4'd0, 4'd0);   // A=B
    step(4'b1001, 4'd0, 4'd0);
    check("post_rst_ab_clear", led, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/td4_cpu.md
# td4_cpu

4-bit single-cycle accumulator CPU in the TD4 style. It has two general registers A and B, an output port register, a 4-bit program counter and a carry flag. It fetches one 8-bit instruction per clock from an external program ROM: the ROM is addressed by `addr` and returns the `opecode` and `imm` fields combinationally. The block sits between that ROM, a 4-bit switch input and a 4-bit LED output.

## Interface
- No parameters. All widths are fixed at 4 bits.
- `clk` — input, 1 bit. Single system clock; all state updates on the rising edge.
- `n_rst` — input, 1 bit. Asynchronous, active-low reset.
- `addr` — output, 4 bits. Program counter; drives the ROM address.
- `opecode` — input, 4 bits. Opcode field of the current instruction (ROM data).
- `imm` — input, 4 bits. Immediate field of the current instruction (ROM data).
- `switch` — input, 4 bits. Input port, sampled by IN instructions.
- `led` — output, 4 bits. Output port register.

## Operation
- State: A, B, OUT (drives `led`), PC (drives `addr`), C (carry flag).
- One instruction executes per clock. Decode and ALU are combinational from `opecode`, `imm`, state and `switch`. Results commit on the rising edge.
- ALU: 4-bit adder, `sum = src + imm`. `src` is selected by opcode from A, B, `switch` or 0. Carry-out is the 5th bit.
- Opcode map (src → destination):
  - 0000 ADD A,Im: A+imm → A
  - 0001 MOV A,B: B+imm → A
  - 0010 IN A: switch+imm → A
  - 0011 MOV A,Im: 0+imm → A
  - 0100 MOV B,A: A+imm → B
  - 0101 ADD B,Im: B+imm → B
  - 0110 IN B: switch+imm → B
  - 0111 MOV B,Im: 0+imm → B
  - 1001 OUT B: B+imm → OUT
  - 1011 OUT Im: 0+imm → OUT
  - 1110 JNC Im: if C==0 then PC←imm, else PC←PC+1
  - 1111 JMP Im: PC←imm
  - 1000, 1010, 1100, 1101: NOP. No register written; PC←PC+1.
- MOV and IN add `imm` to the source, as in TD4. Software uses imm=0 for a plain move.
- PC: loads `imm` on JMP and on taken JNC; otherwise PC←PC+1, wrapping 15→0.
- Carry flag:
  - C is rewritten on every instruction with the adder carry-out of that cycle.
  - Instructions whose src is 0 (MOV x,Im, OUT Im, JMP, JNC, NOPs) always clear C.
  - JNC tests C as held before the edge, i.e. the carry produced by the previous instruction.
- Arithmetic is modulo 16. Overflow sets C only; there is no other status.

## Timing
- Reset (`n_rst`=0, asynchronous, any time including mid-program): A=B=OUT=PC=C=0 immediately. Outputs: `addr`=0, `led`=0.
- Reset release: the first rising edge with `n_rst`=1 executes the instruction at address 0.
- Latency:
  - `addr` changes one edge after a jump decision.
  - `led` updates on the same edge that executes OUT.
  - The new A/B value is usable by the next instruction.
- No handshake. The ROM must present `opecode`/`imm` for `addr` within the same cycle. `switch` is sampled only at the IN execution edge.

## Test plan
- Reset: hold `n_rst`=0 with the clock running → `addr`=0 and `led`=0. Release with opecode=0000, imm=0 → `addr` steps 1, 2, … 15, then wraps to 0; A stays 0.
- IN/MOV/OUT path, one instruction per edge:
  - IN A (0010, imm=0) with switch=3 → A=3.
  - MOV B,A (0100, imm=0) → B=3.
  - IN A with switch=6 → A=6.
  - OUT B (1001, imm=0) → `led`=3.
  - OUT Im (1011, imm=9) → `led`=9.
- Immediate/add: MOV A,Im 10 (0011) → A=10, C=0. ADD A,Im 10 (0000) → A=4, C=1. JNC 7 (1110) → not taken, `addr` = previous+1, C=0.
- JNC taken: MOV A,Im 1, then JNC imm=7 → `addr`=7 on the next edge.
- JMP: at any PC, opecode 1111 with imm=3 → `addr`=3. ADD B,Im 15 with B=1 → B=0, C=1.
- Asynchronous reset mid-program: with A, B, OUT and PC nonzero, pulse `n_rst` low between clock edges → all state clears to 0 without waiting for a clock edge.
